// File: rtl/cga_scandoubler_if.sv
// rtl/cga_scandoubler_if.sv - CGA-side video input and doubled VGA-side video output bundle
interface cga_scandoubler_if;
    logic       ce_in;
    logic [3:0] video_in;
    logic       hsync_in;
    logic       vsync_in;
    logic [3:0] video_out;
    logic       hsync_out;
    logic       vsync_out;

    modport master (
        output ce_in, video_in, hsync_in, vsync_in,
        input  video_out, hsync_out, vsync_out
    );

    modport slave (
        input  ce_in, video_in, hsync_in, vsync_in,
        output video_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/cga_scandoubler.sv
// rtl/cga_scandoubler.sv - CGA line doubler with ping-pong line buffer; CGA_SCANLINES_EN blanks the second pass
module cga_scandoubler #(
    parameter int ADDR_WIDTH      = 10,
    parameter int HSYNC_OUT_WIDTH = 108,
    parameter int DEFAULT_HALF    = 912
) (
    input  logic               clk,
    input  logic               reset,
    cga_scandoubler_if.slave   vid
);
    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam int                    CW       = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [CW-1:0]         CNT_MAX  = '1;
    localparam logic [CW-1:0]         HS_W     = CW'(HSYNC_OUT_WIDTH);
    localparam logic [CW-1:0]         HALF_RST = CW'(DEFAULT_HALF);

    logic                  hsync_q;
    logic                  wr_sel_q,   wr_sel_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
    logic [ADDR_WIDTH-1:0] line_len_q, line_len_d;
    logic [CW-1:0]         in_cnt_q,   in_cnt_d;
    logic [CW-1:0]         half_q,     half_d;
    logic [CW-1:0]         out_h_q,    out_h_d;
    logic                  pass_q,     pass_d;

    logic                  s1_valid_q, s1_hsync_q, s1_vsync_q;
`ifdef CGA_SCANLINES_EN
    logic                  s1_blank_q;
`endif
    logic [3:0]            video_q,    video_d;
    logic                  hsync_o_q;
    logic                  vsync_o_q;

    logic [3:0]            mem0 [DEPTH];
    logic [3:0]            mem1 [DEPTH];
    logic [3:0]            rd_data_q;

    logic                  hs_edge;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  pixel_valid;
    logic                  hsync_raw;

    assign hs_edge     = vid.hsync_in & ~hsync_q;
    assign rd_addr     = out_h_q[ADDR_WIDTH-1:0];
    assign pixel_valid = out_h_q < {2'b00, line_len_q};
    assign hsync_raw   = out_h_q < HS_W;

    always_comb begin
        wr_sel_d   = wr_sel_q;
        wr_addr_d  = wr_addr_q;
        line_len_d = line_len_q;
        half_d     = half_q;
        pass_d     = pass_q;
        out_h_d    = out_h_q + CW'(1);
        in_cnt_d   = (in_cnt_q == CNT_MAX) ? in_cnt_q : in_cnt_q + CW'(1);
        wr_en      = 1'b0;
        wr_idx     = wr_addr_q;

        if (hs_edge) begin
            // New line: swap buffers, latch the finished line's length and period
            wr_sel_d   = ~wr_sel_q;
            line_len_d = wr_addr_q;
            in_cnt_d   = CW'(1);
            if (in_cnt_q[CW-1:1] != '0) begin
                half_d = {1'b0, in_cnt_q[CW-1:1]};
            end
            out_h_d = '0;
            pass_d  = 1'b0;
            if (vid.ce_in) begin
                wr_en     = 1'b1;
                wr_idx    = '0;
                wr_addr_d = ADDR_WIDTH'(1);
            end else begin
                wr_addr_d = '0;
            end
        end else begin
            if (vid.ce_in && (wr_addr_q != ADDR_MAX)) begin
                wr_en     = 1'b1;
                wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            end
            if (out_h_q == half_q - CW'(1)) begin
                out_h_d = '0;
                pass_d  = ~pass_q;
            end
        end
    end

    always_comb begin
        video_d = s1_valid_q ? rd_data_q : 4'h0;
`ifdef CGA_SCANLINES_EN
        if (s1_blank_q) begin
            video_d = 4'h0;
        end
`endif
    end

    // Line buffers: writes land in the buffer selected after this edge's toggle
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            if (wr_sel_d) begin
                mem1[wr_idx] <= vid.video_in;
            end else begin
                mem0[wr_idx] <= vid.video_in;
            end
        end
        rd_data_q <= wr_sel_q ? mem0[rd_addr] : mem1[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q    <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_addr_q  <= '0;
            line_len_q <= '0;
            in_cnt_q   <= '0;
            half_q     <= HALF_RST;
            out_h_q    <= '0;
            pass_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_hsync_q <= 1'b0;
            s1_vsync_q <= 1'b0;
`ifdef CGA_SCANLINES_EN
            s1_blank_q <= 1'b0;
`endif
            video_q    <= 4'h0;
            hsync_o_q  <= 1'b0;
            vsync_o_q  <= 1'b0;
        end else begin
            hsync_q    <= vid.hsync_in;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            line_len_q <= line_len_d;
            in_cnt_q   <= in_cnt_d;
            half_q     <= half_d;
            out_h_q    <= out_h_d;
            pass_q     <= pass_d;
            // First stage runs alongside the RAM read register
            s1_valid_q <= pixel_valid;
            s1_hsync_q <= hsync_raw;
            s1_vsync_q <= vid.vsync_in;
`ifdef CGA_SCANLINES_EN
            s1_blank_q <= pass_q;
`endif
            video_q    <= video_d;
            hsync_o_q  <= s1_hsync_q;
            vsync_o_q  <= s1_vsync_q;
        end
    end

    assign vid.video_out = video_q;
    assign vid.hsync_out = hsync_o_q;
    assign vid.vsync_out = vsync_o_q;
endmodule

// File: tb/tb_cga_scandoubler.sv
// tb/tb_cga_scandoubler.sv - randomized line stimulus checked against a line-level reference model
module tb_cga_scandoubler;
    logic  clk = 1'b0;
    logic  reset;
    bit    ce_ph = 1'b0;
    bit    chk_en = 1'b0;
    string cur_tag = "reset";
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    cga_scandoubler_if vif ();

    cga_scandoubler #(
        .ADDR_WIDTH     (10),
        .HSYNC_OUT_WIDTH(108),
        .DEFAULT_HALF   (912)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vid  (vif)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: current position = clocks since the last line start, split into passes of half_period
    int         m_since = 0;
    int         m_half  = 912;
    int         m_incnt = 0;
    int         m_len   = 0;
    int         m_wcnt  = 0;
    bit         m_hsq   = 1'b0;
    logic [3:0] m_prev [1024];
    logic [3:0] m_cur  [1024];
    logic [5:0] m_s1 = '0;
    logic [5:0] m_s2 = '0;

    function automatic logic [5:0] raw_out(input logic vs);
        int         oh;
        int         ps;
        logic [3:0] px;
        oh = m_since % m_half;
        ps = (m_since / m_half) % 2;
        px = (oh < m_len) ? m_prev[oh] : 4'h0;
`ifdef CGA_SCANLINES_EN
        if (ps == 1) px = 4'h0;
`endif
        return {px, (oh < 108) ? 1'b1 : 1'b0, vs};
    endfunction

    task automatic model_reset();
        m_since = 0;
        m_half  = 912;
        m_incnt = 0;
        m_len   = 0;
        m_wcnt  = 0;
        m_hsq   = 1'b0;
    endtask

    task automatic model_step(input logic ce, input logic [3:0] v, input logic hs);
        bit edge_now;
        edge_now = hs && !m_hsq;
        m_hsq = hs;
        if (edge_now) begin
            if ((m_incnt / 2) != 0) m_half = m_incnt / 2;
            m_incnt = 1;
            m_len   = m_wcnt;
            for (int i = 0; i < 1024; i++) m_prev[i] = m_cur[i];
            m_wcnt  = 0;
            m_since = 0;
            if (ce) begin
                m_cur[0] = v;
                m_wcnt   = 1;
            end
        end else begin
            if (m_incnt < 4095) m_incnt++;
            m_since++;
            if (ce && m_wcnt < 1023) begin
                m_cur[m_wcnt] = v;
                m_wcnt++;
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0;
            m_s2 = '0;
            model_reset();
        end else begin
            m_s2 = m_s1;
            m_s1 = raw_out(vif.vsync_in);
            model_step(vif.ce_in, vif.video_in, vif.hsync_in);
        end
        #1;
        if (chk_en) check_eq(cur_tag, {26'd0, vif.video_out, vif.hsync_out, vif.vsync_out}, {26'd0, m_s2});
    end

    function automatic logic [3:0] pix_val(input int mode, input int pix);
        case (mode)
            0:       return 4'(pix % 16);
            1:       return 4'($urandom);
            2:       return 4'hF;
            default: return 4'hA;
        endcase
    endfunction

    // edge_ce: 0 = no pixel on the hsync edge, 1 = pixel on the edge, 2 = free-running phase
    task automatic run_line(input int period, input int npix, input int mode,
                            input int rst_at, input int edge_ce);
        int pix = 0;
        for (int c = 0; c < period; c++) begin
            @(negedge clk);
            ce_ph = ~ce_ph;
            if (c == 0 && edge_ce != 2) ce_ph = (edge_ce == 1);
            reset        = (rst_at >= 0 && c >= rst_at && c < rst_at + 3);
            vif.hsync_in = (c < 100);
            vif.ce_in    = ce_ph && (pix < npix);
            if (vif.ce_in) begin
                vif.video_in = pix_val(mode, pix);
                pix++;
            end else begin
                vif.video_in = 4'($urandom);
            end
            if ($urandom_range(0, 199) == 0) vif.vsync_in = ~vif.vsync_in;
        end
    endtask

    initial begin
        reset        = 1'b1;
        vif.ce_in    = 1'b0;
        vif.video_in = 4'h0;
        vif.hsync_in = 1'b0;
        vif.vsync_in = 1'b0;
        @(posedge clk);
        #2 chk_en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            vif.ce_in    = 1'($urandom);
            vif.video_in = 4'($urandom);
            vif.hsync_in = 1'($urandom);
            vif.vsync_in = 1'($urandom);
        end
        @(negedge clk);
        reset        = 1'b0;
        vif.hsync_in = 1'b0;
        vif.ce_in    = 1'b0;
        vif.vsync_in = 1'b0;
        repeat (20) @(negedge clk);

        cur_tag = "first_line";
        run_line(1824, 640, 0, -1, 0);
        cur_tag = "nominal";
        run_line(1824, 640, 0, -1, 0);
        run_line(1824, 640, 0, -1, 0);
        cur_tag = "simultaneous";
        run_line(1824, 640, 3, -1, 1);
        run_line(1824, 640, 1, -1, 0);
        cur_tag = "overflow";
        run_line(2400, 1100, 1, -1, 2);
        run_line(1824, 640, 1, -1, 2);
        cur_tag = "short_line";
        run_line(1000, 400, 1, -1, 2);
        run_line(1824, 640, 1, -1, 2);
        cur_tag = "all_f";
        run_line(1824, 640, 2, -1, 0);
        run_line(1824, 640, 2, -1, 0);
        cur_tag = "mid_reset";
        run_line(1824, 640, 1, 900, 2);
        run_line(1824, 640, 1, -1, 2);
        run_line(1824, 640, 1, -1, 2);
        cur_tag = "cnt_saturate";
        run_line(4300, 700, 1, -1, 2);
        run_line(1824, 640, 1, -1, 2);
        cur_tag = "random";
        for (int n = 0; n < 12; n++) begin
            run_line($urandom_range(300, 2600), $urandom_range(0, 1100),
                     $urandom_range(0, 3), -1, $urandom_range(0, 2));
        end
        cur_tag = "tail";
        run_line(1824, 0, 0, -1, 0);
        repeat (50) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
